mimo_fifo_n: RTL and testbench
==============================

MIMO_FIFO_N -- requirements
Module: mimo_fifo_n

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data bits per lane.
REQ-002 SHALL have parameter DEPTH, default 16: entries per branch FIFO; power of 2; DEPTH >= NUM_PORTS.
REQ-003 SHALL have parameter NUM_PORTS, default 8: input lanes = output branches; power of 2, 2..16. BW = log2(NUM_PORTS).
REQ-004 SHALL have port i_clock, input, 1: the single clock; all state on rising edge.
REQ-005 SHALL have port i_reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port i_data, input, NUM_PORTS*WIDTH: lane k data at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port i_to_branch, input, NUM_PORTS*BW: lane k destination branch at [k*BW +: BW].
REQ-008 SHALL have port i_lane_en, input, NUM_PORTS: per-lane write enable within a group.
REQ-009 SHALL have port i_valid, input, 1: group write request for all enabled lanes.
REQ-010 SHALL have port o_ready, output, 1: group write accepted this cycle when high.
REQ-011 SHALL have port o_data, output, NUM_PORTS*WIDTH: branch b head data at [b*WIDTH +: WIDTH].
REQ-012 SHALL have port o_valid, output, NUM_PORTS: branch b FIFO non-empty.
REQ-013 SHALL have port i_ready, input, NUM_PORTS: branch b consumer ready (per-branch backpressure).

Function
REQ-014 SHALL hold one FIFO of DEPTH x WIDTH per branch, with a count register of log2(DEPTH)+1 bits.
REQ-015 SHALL accept a group on a rising edge only when i_valid && o_ready; otherwise inputs are ignored and no state changes from the write side.
REQ-016 SHALL, on acceptance, push i_data lane k into FIFO i_to_branch[k] for every k with i_lane_en[k]=1; disabled lanes are discarded.
REQ-017 SHALL, when several enabled lanes target one branch in a group, push them in ascending lane order in that same cycle.
REQ-018 SHALL drive o_ready=1 iff every branch FIFO has at least NUM_PORTS free entries; o_ready depends only on registered counts, with no combinational path from any input.
REQ-019 SHALL be first-word-fall-through: o_valid[b]=(count_b!=0); o_data lane b = FIFO b head, or 0 when o_valid[b]=0.
REQ-020 SHALL pop one entry from branch b on a rising edge where o_valid[b] && i_ready[b].
REQ-021 SHALL, on a simultaneous push(es) and pop on one branch, update count_b += pushes - pop; a pop of the old head is legal in the same cycle as pushes.
REQ-022 SHALL give latency 1: data pushed at edge N appears on o_valid/o_data after edge N; an empty branch never bypasses input to output combinationally.
REQ-023 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entries.
REQ-024 SHALL keep branches independent: backpressure on branch b stalls other branches only through o_ready.

Reset
REQ-025 SHALL, while i_reset=1, immediately clear all counts and pointers, so o_valid=0, o_data=0, o_ready=1; FIFO memory contents need not be cleared.
REQ-026 SHALL, on reset mid-operation, discard all queued entries; no entry queued before reset appears after release.
REQ-027 SHALL accept a group on the first rising edge after i_reset deasserts.

Verification (NUM_PORTS=8, DEPTH=16, WIDTH=16)
REQ-028 SHALL cover idle: reset, i_valid=0 for 1000 cycles -> o_valid=0x00, o_ready=1 throughout.
REQ-029 SHALL cover fan-out: lane k data=k, branch=k, i_lane_en=0xFF, i_ready=0xFF, one group -> each o_valid[k] high exactly 1 cycle, after the next edge, with o_data lane k = k.
REQ-030 SHALL cover collapse: all lanes to branch 3, data 0x10..0x17 -> branch 3 emits 0x10..0x17 in order over 8 consecutive cycles; other o_valid stay 0.
REQ-031 SHALL cover backpressure: i_ready[3]=0, groups of 8 to branch 3 -> after group 1 o_ready=1; after group 2 (count 16) o_ready=0 and a held i_valid is not accepted; set i_ready[3]=1 -> o_ready returns to 1 once count<=8, and all 16+ words emerge in order.
REQ-032 SHALL cover mask: i_lane_en=0x05, lanes to branches 0..7 -> only branches 0 and 2 emit, with data from lanes 0 and 2.
REQ-033 SHALL cover reset mid-stream: 12 words queued on branch 5, i_reset pulsed -> o_valid=0x00 before the next edge; after release no stale words appear, and new writes behave per REQ-029.

Source files
------------

// File: rtl/mimo_fifo_n.sv
// Multi-input, multi-output FIFO: each accepted group scatters up to NUM_PORTS lanes
// into per-branch first-word-fall-through queues that drain independently.
module mimo_fifo_n #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int NUM_PORTS = 8,
    localparam int BW       = $clog2(NUM_PORTS),
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NUM_PORTS*WIDTH-1:0] i_data,
    input  logic [NUM_PORTS*BW-1:0]    i_to_branch,
    input  logic [NUM_PORTS-1:0]       i_lane_en,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [NUM_PORTS*WIDTH-1:0] o_data,
    output logic [NUM_PORTS-1:0]       o_valid,
    input  logic [NUM_PORTS-1:0]       i_ready
);

    logic [WIDTH-1:0] mem      [NUM_PORTS][DEPTH];
    logic [AW-1:0]    wr_ptr   [NUM_PORTS];
    logic [AW-1:0]    rd_ptr   [NUM_PORTS];
    logic [CW-1:0]    count    [NUM_PORTS];

    logic [WIDTH-1:0]     lane_data   [NUM_PORTS];
    logic [BW-1:0]        lane_branch [NUM_PORTS];
    logic [NUM_PORTS-1:0] lane_hit    [NUM_PORTS];
    logic [AW-1:0]        slot_addr   [NUM_PORTS][NUM_PORTS];
    logic [CW-1:0]        push_cnt    [NUM_PORTS];
    logic [NUM_PORTS-1:0] pop;
    logic                 accept;

    assign accept = i_valid && o_ready;

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            lane_data[k]   = i_data[k*WIDTH +: WIDTH];
            lane_branch[k] = i_to_branch[k*BW +: BW];
        end
    end

    // Lanes aimed at the same branch take consecutive slots in ascending lane order.
    always_comb begin
        for (int b = 0; b < NUM_PORTS; b++) begin
            push_cnt[b] = '0;
            lane_hit[b] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                slot_addr[b][k] = '0;
                if (accept && i_lane_en[k] && lane_branch[k] == BW'(b)) begin
                    lane_hit[b][k]  = 1'b1;
                    slot_addr[b][k] = wr_ptr[b] + push_cnt[b][AW-1:0];
                    push_cnt[b]     = push_cnt[b] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        o_ready = 1'b1;
        o_valid = '0;
        o_data  = '0;
        pop     = '0;
        for (int b = 0; b < NUM_PORTS; b++) begin
            if (count[b] > CW'(DEPTH - NUM_PORTS))
                o_ready = 1'b0;
            if (count[b] != '0) begin
                o_valid[b]               = 1'b1;
                o_data[b*WIDTH +: WIDTH] = mem[b][rd_ptr[b]];
                pop[b]                   = i_ready[b];
            end
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by count, so stale contents are never visible.
    always_ff @(posedge i_clock) begin
        for (int b = 0; b < NUM_PORTS; b++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (lane_hit[b][k])
                    mem[b][slot_addr[b][k]] <= lane_data[k];
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every branch updates from pre-edge values.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int b = 0; b < NUM_PORTS; b++) begin
                wr_ptr[b] <= '0;
                rd_ptr[b] <= '0;
                count[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_PORTS; b++) begin
                wr_ptr[b] <= wr_ptr[b] + push_cnt[b][AW-1:0];
                if (pop[b])
                    rd_ptr[b] <= rd_ptr[b] + AW'(1);
                count[b] <= count[b] + push_cnt[b] - CW'(pop[b]);
            end
        end
    end

endmodule

// File: tb/tb_mimo_fifo_n.sv
// Directed bench for mimo_fifo_n: per-branch ordering is tracked by a scoreboard queue
// that the stimulus fills and a negedge monitor drains.
module tb_mimo_fifo_n;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int NP = 8;
    localparam int BW = 3;

    logic              i_clock = 1'b0;
    logic              i_reset = 1'b1;
    logic [NP*W-1:0]   i_data = '0;
    logic [NP*BW-1:0]  i_to_branch = '0;
    logic [NP-1:0]     i_lane_en = '0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [NP*W-1:0]   o_data;
    logic [NP-1:0]     o_valid;
    logic [NP-1:0]     i_ready = '0;

    typedef struct {
        int          br;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mimo_fifo_n #(.WIDTH(W), .DEPTH(D), .NUM_PORTS(NP)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_data      (i_data),
        .i_to_branch (i_to_branch),
        .i_lane_en   (i_lane_en),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    // Drive one group for a single edge; o_ready is expected high so the group is accepted.
    task automatic send_group(input logic [NP*W-1:0] d, input logic [NP*BW-1:0] br,
                              input logic [NP-1:0] en);
        i_data      = d;
        i_to_branch = br;
        i_lane_en   = en;
        i_valid     = 1'b1;
        check("ready_before_group", 128'(o_ready), 128'(1));
        for (int k = 0; k < NP; k++)
            if (en[k]) exp_q.push_back('{int'(br[k*BW +: BW]), d[k*W +: W]});
        step();
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            step();
        check({tag, "_sb_empty"}, 128'(exp_q.size()), 128'(0));
        check({tag, "_valid_idle"}, 128'(o_valid), 128'(0));
    endtask

    // Monitor: a beat is consumed at the next edge when valid and ready are both high.
    always @(negedge i_clock) begin : mon
        int  idx;
        bit  found;
        if (!i_reset) begin
            for (int b = 0; b < NP; b++) begin
                if (o_valid[b] && i_ready[b]) begin
                    found = 1'b0;
                    idx   = 0;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (!found && exp_q[i].br == b) begin
                            found = 1'b1;
                            idx   = i;
                        end
                    if (found) begin
                        check($sformatf("sb_data_b%0d", b), 128'(o_data[b*W +: W]), 128'(exp_q[idx].data));
                        exp_q.delete(idx);
                    end else begin
                        check($sformatf("sb_extra_b%0d", b), 128'(o_valid[b]), 128'(0));
                    end
                end
            end
        end
    end

    initial begin
        logic [NP*W-1:0]  gd;
        logic [NP*BW-1:0] gb;
        logic [NP*BW-1:0] gb3;
        logic [NP*BW-1:0] gb5;
        int               idle_bad;

        for (int k = 0; k < NP; k++) begin
            gb[k*BW +: BW]  = BW'(k);
            gb3[k*BW +: BW] = 3'd3;
            gb5[k*BW +: BW] = 3'd5;
        end

        // Reset state
        #1;
        check("rst_valid", 128'(o_valid), 128'(0));
        check("rst_ready", 128'(o_ready), 128'(1));
        check("rst_data", 128'(o_data), 128'(0));
        step();
        step();
        i_reset = 1'b0;

        // Idle for 1000 cycles
        idle_bad = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (o_valid !== 8'h00 || o_ready !== 1'b1) idle_bad++;
        end
        check("idle_cycles_bad", 128'(idle_bad), 128'(0));

        // Fan-out: lane k -> branch k
        i_ready = 8'hFF;
        for (int k = 0; k < NP; k++) gd[k*W +: W] = W'(k);
        send_group(gd, gb, 8'hFF);
        check("fanout_valid", 128'(o_valid), 128'(8'hFF));
        step();
        check("fanout_valid_after", 128'(o_valid), 128'(0));
        drain("fanout");

        // Collapse: all lanes -> branch 3, emitted in lane order
        for (int k = 0; k < NP; k++) gd[k*W +: W] = W'(16'h10 + k);
        send_group(gd, gb3, 8'hFF);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("collapse_valid_c%0d", c), 128'(o_valid), 128'(8'h08));
            step();
        end
        check("collapse_done", 128'(o_valid), 128'(0));
        drain("collapse");

        // Backpressure on branch 3
        i_ready = 8'hF7;
        for (int k = 0; k < NP; k++) gd[k*W +: W] = W'(16'h100 + k);
        send_group(gd, gb3, 8'hFF);
        check("bp_ready_g1", 128'(o_ready), 128'(1));
        for (int k = 0; k < NP; k++) gd[k*W +: W] = W'(16'h200 + k);
        send_group(gd, gb3, 8'hFF);
        check("bp_ready_g2", 128'(o_ready), 128'(0));
        for (int k = 0; k < NP; k++) gd[k*W +: W] = W'(16'hDEAD);
        i_data      = gd;
        i_to_branch = gb3;
        i_lane_en   = 8'hFF;
        i_valid     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp_held_ready_c%0d", c), 128'(o_ready), 128'(0));
        end
        i_valid = 1'b0;
        i_ready = 8'hFF;
        for (int j = 1; j <= 8; j++) begin
            step();
            check($sformatf("bp_release_ready_j%0d", j), 128'(o_ready), 128'(j >= 8));
        end
        for (int k = 0; k < NP; k++) gd[k*W +: W] = W'(16'h300 + k);
        send_group(gd, gb3, 8'hFF);
        drain("bp");

        // Lane mask 0x05
        for (int k = 0; k < NP; k++) gd[k*W +: W] = W'(16'h500 + k);
        send_group(gd, gb, 8'h05);
        check("mask_valid", 128'(o_valid), 128'(8'h05));
        step();
        check("mask_valid_after", 128'(o_valid), 128'(0));
        drain("mask");

        // Reset mid-stream with 12 words held on branch 5
        i_ready = 8'hDF;
        for (int k = 0; k < NP; k++) gd[k*W +: W] = W'(16'h600 + k);
        send_group(gd, gb5, 8'hFF);
        send_group(gd, gb5, 8'h0F);
        check("mid_valid_b5", 128'(o_valid), 128'(8'h20));
        check("mid_ready_full", 128'(o_ready), 128'(0));
        #2;
        i_reset = 1'b1;
        #1;
        check("mid_rst_valid", 128'(o_valid), 128'(0));
        check("mid_rst_ready", 128'(o_ready), 128'(1));
        check("mid_rst_data", 128'(o_data), 128'(0));
        exp_q.delete();
        step();
        i_reset = 1'b0;
        i_ready = 8'hFF;
        for (int k = 0; k < NP; k++) gd[k*W +: W] = W'(16'h700 + k);
        send_group(gd, gb, 8'hFF);
        check("post_rst_valid", 128'(o_valid), 128'(8'hFF));
        step();
        check("post_rst_valid_after", 128'(o_valid), 128'(0));
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
